// File: rtl/conv_kxk.sv
// K x K sliding-window convolution engine for the ISP pixel pipeline.
// Accepts one K-pixel column per cycle, multiplies the window by a
// double-buffered signed kernel and emits one rounded / optionally clamped
// result per accepted column, three cycles after the column is sampled.
module conv_kxk #(
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int CW    = 16,
  parameter int SHIFT = 0,
  parameter int SAT   = 1,
  localparam int AW   = $clog2(K * K),
  localparam int ACCW = DW + CW + 1 + AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_done,
  input  logic [K*DW-1:0]   i_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [CW-1:0]     coef_data,
  input  logic              coef_commit,
  output logic              o_valid,
  output logic              o_img_done,
  output logic [ACCW-1:0]   o_data,
  output logic              o_busy
);

  localparam int NT   = K * K;
  localparam int PW   = DW + CW + 1;
  localparam int CNTW = $clog2(K + 1);
  localparam int CTR  = (K / 2) * K + (K / 2);
  // Half an output LSB; evaluates to zero when no shift is applied.
  localparam logic [ACCW-1:0] RND_C  = (ACCW'(1) << SHIFT) >> 1;
  localparam logic [ACCW-1:0] MAXV_C = {{(ACCW-DW){1'b0}}, {DW{1'b1}}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              busy_nx_s;
  logic              busy_r;

  logic [DW-1:0]     win_r [K][K];
  logic [CNTW-1:0]   cnt_r;
  logic              warm_s;

  logic [CW-1:0]     shd_r [NT];
  logic [CW-1:0]     act_r [NT];
  logic              pend_r;
  logic              copy_s;

  logic [PW-1:0]     prod_r [NT];
  logic [ACCW-1:0]   sum_s;
  logic [ACCW-1:0]   sum_r;

  logic              v1_r, v2_r, v3_r;
  logic              d1_r, d2_r, d3_r;
  logic              o_valid_r;
  logic              o_done_r;
  logic [ACCW-1:0]   o_data_r;

  // Identity kernel: only the centre tap is non-zero, scaled to cancel SHIFT.
  function automatic logic [CW-1:0] ident_coef(input int a);
    logic [CW-1:0] v;
    if (a == CTR) v = CW'(1) << SHIFT;
    else          v = '0;
    return v;
  endfunction

  // Unsigned pixel times signed coefficient, full-precision signed product.
  function automatic logic [PW-1:0] tap_product(input logic [DW-1:0] pix,
                                                input logic [CW-1:0] cf);
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] ce;
    pe = $signed({{(CW+1){1'b0}}, pix});
    ce = $signed({{(DW+1){cf[CW-1]}}, cf});
    return pe * ce;
  endfunction

  // Round-half-up arithmetic shift, then optional clamp to the pixel range.
  function automatic logic [ACCW-1:0] scale_result(input logic [ACCW-1:0] s);
    logic signed [ACCW-1:0] rs;
    logic [ACCW-1:0]        res;
    rs = $signed(s + RND_C) >>> SHIFT;
    if (SAT != 0) begin
      if (rs[ACCW-1])                res = '0;
      else if (rs > $signed(MAXV_C)) res = MAXV_C;
      else                           res = rs;
    end else begin
      res = rs;
    end
    return res;
  endfunction

  assign warm_s = (cnt_r >= CNTW'(K - 1));
  assign copy_s = (state_r == ST_IDLE) && pend_r;

  // FSM state and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  // FSM next state: an image opens on a non-final column and closes on i_done.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid && !i_done) state_nx_s = ST_ACTIVE;
        else                    state_nx_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (i_valid && i_done) state_nx_s = ST_IDLE;
        else                   state_nx_s = ST_ACTIVE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output: busy follows the ACTIVE state, registered alongside it.
  always_comb begin
    busy_nx_s = 1'b0;
    if (state_nx_s == ST_ACTIVE) busy_nx_s = 1'b1;
    else                         busy_nx_s = 1'b0;
  end

  // Sliding window: new column enters age 0, older columns age by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_r[r][c] <= '0;
    end else if (i_valid) begin
      for (int r = 0; r < K; r++) begin
        win_r[r][0] <= i_data[(K-r)*DW-1 -: DW];
        for (int c = 1; c < K; c++)
          win_r[r][c] <= win_r[r][c-1];
      end
    end
  end

  // Warm-up counter: saturates at K, restarts after the last column of an image.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (i_valid) begin
      if (i_done)                   cnt_r <= '0;
      else if (cnt_r != CNTW'(K))   cnt_r <= cnt_r + 1'b1;
    end
  end

  // Shadow coefficient bank, written by the host at any time.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NT; a++) shd_r[a] <= ident_coef(a);
    end else begin
      for (int a = 0; a < NT; a++)
        if (coef_we && (coef_addr == AW'(a))) shd_r[a] <= coef_data;
    end
  end

  // Active bank: copied from shadow (including this edge's write) only between images.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NT; a++) act_r[a] <= ident_coef(a);
    end else if (copy_s) begin
      for (int a = 0; a < NT; a++)
        act_r[a] <= (coef_we && (coef_addr == AW'(a))) ? coef_data : shd_r[a];
    end
  end

  // Commit request is held until the engine is idle and the copy happens.
  always_ff @(posedge clk) begin
    if (reset) pend_r <= 1'b0;
    else       pend_r <= coef_commit | (pend_r & ~copy_s);
  end

  // Stage 1: per-tap products using the active bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NT; a++) prod_r[a] <= '0;
    end else begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod_r[r*K+c] <= tap_product(win_r[r][c], act_r[r*K+c]);
    end
  end

  // Adder tree over all taps, sign-extended so it cannot overflow.
  always_comb begin
    sum_s = '0;
    for (int a = 0; a < NT; a++)
      sum_s = sum_s + {{AW{prod_r[a][PW-1]}}, prod_r[a]};
  end

  // Stage 2: registered sum.
  always_ff @(posedge clk) begin
    if (reset) sum_r <= '0;
    else       sum_r <= sum_s;
  end

  // Valid / image-done markers travelling alongside the data pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
      d1_r <= 1'b0; d2_r <= 1'b0; d3_r <= 1'b0;
    end else begin
      v1_r <= i_valid & warm_s;
      d1_r <= i_valid & i_done;
      v2_r <= v1_r;
      d2_r <= d1_r;
      v3_r <= v2_r;
      d3_r <= d2_r;
    end
  end

  // Stage 3: scaled output; data holds its last value between valid results.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid_r <= 1'b0;
      o_done_r  <= 1'b0;
      o_data_r  <= '0;
    end else begin
      o_valid_r <= v3_r;
      o_done_r  <= d3_r;
      if (v3_r) o_data_r <= scale_result(sum_r);
    end
  end

  assign o_valid    = o_valid_r;
  assign o_img_done = o_done_r;
  assign o_data     = o_data_r;
  assign o_busy     = busy_r;

endmodule
